// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller (master) and the shared datapath (slave).
// The master receives instruction fields and ALU flags and drives every datapath enable and mux select.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       zero;
    logic       neg;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [2:0] imm_src;
    logic       illegal;

    modport master (
        input  opcode, func3, zero, neg,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal
    );

    modport slave (
        output opcode, func3, zero, neg,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared datapath one instruction at a time.
// Define ILLEGAL_HALT_EN to stop in a HALT state on an unsupported opcode; otherwise it is skipped as a NOP.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.master bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        MEM_ADR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH,
        JAL,
        JALR,
        JALR_PC,
`ifdef ILLEGAL_HALT_EN
        HALT,
`endif
        LUI
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [2:0] imm_src;
    logic       illegal;
    logic       taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (bus.func3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.neg;
            3'b101:  taken = ~bus.neg;
            default: taken = 1'b0;
        endcase
    end

    // imm_src follows the opcode in every state so the immediate is ready whenever a state needs it.
    always_comb begin
        case (bus.opcode)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
`ifdef ILLEGAL_HALT_EN
                    default:           state_d = HALT;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                adr_src = 1'b1;
                state_d = MEM_WB;
            end
            MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = taken;
                state_d   = FETCH;
            end
            // JAL loads the target computed in DECODE while the ALU forms the link address OldPC+4.
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALU_WB;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = JALR_PC;
            end
            JALR_PC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALU_WB;
            end
            LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
`ifdef ILLEGAL_HALT_EN
            HALT: begin
                illegal = 1'b1;
                state_d = HALT;
            end
`endif
            default: state_d = FETCH;
        endcase

        // Reset parks the datapath on the FETCH selects with every write enable held off.
        if (rst) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            result_src = 2'b10;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            illegal    = 1'b0;
            state_d    = FETCH;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.reg_write  = reg_write;
    assign bus.imm_src    = imm_src;
    assign bus.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction expands into a list of per-cycle control words
// built from instruction-class phase tables, compared cycle by cycle against the controller outputs.
module tb_multicycle_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic halted;
    logic [14:0] exp_q[$];

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [6:0] legal_ops [8];

    multicycle_controller_if bus_if ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal.
    function automatic logic [14:0] mk(input logic pc, input logic adr, input logic mw, input logic ir,
                                       input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic rw, input logic ill);
        return {pc, adr, mw, ir, rs, a, b, op, rw, ill};
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == OP_STORE)  return 3'b001;
        if (op == OP_BRANCH) return 3'b010;
        if (op == OP_JAL)    return 3'b011;
        if (op == OP_LUI)    return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return n;
        if (f3 == 3'd5) return !n;
        return 1'b0;
    endfunction

    function automatic logic [14:0] reset_word();
        return mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    endfunction

    task automatic buildExpected(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic n);
        exp_q.delete();
        halted = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0));
        if (op == OP_LOAD || op == OP_STORE) begin
            exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
            if (op == OP_LOAD) begin
                exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0));
            end else begin
                exp_q.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
            end
        end else if (op == OP_RTYPE || op == OP_ITYPE) begin
            if (op == OP_RTYPE) exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
            else                exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b11, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
        end else if (op == OP_BRANCH) begin
            exp_q.push_back(mk(branch_taken(f3, z, n), 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0));
        end else if (op == OP_JAL || op == OP_JALR) begin
            if (op == OP_JALR) exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0));
            exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
        end else if (op == OP_LUI) begin
            exp_q.push_back(mk(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0));
        end else begin
`ifdef ILLEGAL_HALT_EN
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
            halted = 1'b1;
`endif
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic n);
        bus_if.opcode = op;
        bus_if.func3  = f3;
        bus_if.zero   = z;
        bus_if.neg    = n;
    endtask

    task automatic checkOutput(input string tag, input logic [14:0] exp_word, input logic [2:0] exp_imm);
        logic [14:0] obs;
        obs = {bus_if.pc_write, bus_if.adr_src, bus_if.mem_write, bus_if.ir_write, bus_if.result_src,
               bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write, bus_if.illegal};
        checks++;
        assert (obs === exp_word) else begin
            errors++;
            $error("[TB] FAIL %s ctrl: got %b expected %b", tag, obs, exp_word);
        end
        checks++;
        assert (bus_if.imm_src === exp_imm) else begin
            errors++;
            $error("[TB] FAIL %s imm_src: got %b expected %b", tag, bus_if.imm_src, exp_imm);
        end
    endtask

    // Runs one instruction from FETCH; abort_at >= 0 asserts rst in that cycle instead of finishing.
    task automatic runInstr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic z, input logic n, input int abort_at);
        int stop;
        buildExpected(op, f3, z, n);
        applyStimulus(op, f3, z, n);
        stop = exp_q.size();
        if (abort_at >= 0 && abort_at < stop) stop = abort_at;
        for (int i = 0; i < stop; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_c%0d", name, i), exp_q[i], imm_of(op));
            @(posedge clk);
            #1;
        end
        if (stop < exp_q.size() || halted) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("%s_rst", name), reset_word(), imm_of(op));
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        logic [6:0] op;
        checks = 0;
        errors = 0;
        halted = 1'b0;
        legal_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
        rst = 1'b1;
        applyStimulus(OP_RTYPE, 3'b000, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_c%0d", i), reset_word(), imm_of(OP_RTYPE));
            @(posedge clk);
        end
        #1;
        rst = 1'b0;

        $display("[TB] directed instructions");
        runInstr("rtype", OP_RTYPE, 3'b000, 1'b0, 1'b0, -1);
        runInstr("lw", OP_LOAD, 3'b010, 1'b1, 1'b0, -1);
        runInstr("sw", OP_STORE, 3'b010, 1'b0, 1'b1, -1);
        runInstr("itype", OP_ITYPE, 3'b000, 1'b0, 1'b0, -1);
        runInstr("beq_t", OP_BRANCH, 3'b000, 1'b1, 1'b0, -1);
        runInstr("beq_nt", OP_BRANCH, 3'b000, 1'b0, 1'b0, -1);
        runInstr("bne_t", OP_BRANCH, 3'b001, 1'b0, 1'b1, -1);
        runInstr("blt_t", OP_BRANCH, 3'b100, 1'b0, 1'b1, -1);
        runInstr("bge_t", OP_BRANCH, 3'b101, 1'b1, 1'b0, -1);
        runInstr("bge_nt", OP_BRANCH, 3'b101, 1'b0, 1'b1, -1);
        runInstr("f3_010", OP_BRANCH, 3'b010, 1'b1, 1'b1, -1);
        runInstr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, -1);
        runInstr("jalr", OP_JALR, 3'b000, 1'b0, 1'b0, -1);
        runInstr("lui", OP_LUI, 3'b111, 1'b1, 1'b1, -1);
        runInstr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, -1);
        runInstr("sw_rst", OP_STORE, 3'b010, 1'b0, 1'b0, 3);
        runInstr("lw_rst", OP_LOAD, 3'b010, 1'b0, 1'b0, 1);
        runInstr("after_rst", OP_RTYPE, 3'b000, 1'b0, 1'b0, -1);

        $display("[TB] randomized instructions");
        for (int t = 0; t < 60; t++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 8) begin
                op = legal_ops[sel];
            end else begin
                op = 7'($urandom);
                for (int k = 0; k < 8; k++) if (op == legal_ops[k]) op = 7'b0000000;
            end
            runInstr($sformatf("rnd%0d", t), op, 3'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
